// File: rtl/poly_resamp_fir.sv
// Polyphase fractional resampler: interpolates two adjacent LUT coefficient rows
// by the fractional phase and runs a 6-tap complex FIR over the sample history.
module poly_resamp_fir #(
  parameter int P_LEN        = 6,
  parameter int L_LDN        = 6,
  parameter int FIR_CO_WIDTH = 14,
  parameter int DW           = 16,
  parameter int FRAC_W       = 8,
  parameter int PH_W         = L_LDN + FRAC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_i,
  input  logic                           clr_i,
  input  logic [PH_W+1:0]                step_i,
  input  logic                           in_vld_i,
  output logic                           in_rdy_o,
  input  logic signed [DW-1:0]           in_i_i,
  input  logic signed [DW-1:0]           in_q_i,
  output logic [L_LDN:0]                 rd_addr1_o,
  output logic [L_LDN:0]                 rd_addr2_o,
  input  logic [P_LEN*FIR_CO_WIDTH-1:0]  rd_data1_i,
  input  logic [P_LEN*FIR_CO_WIDTH-1:0]  rd_data2_i,
  output logic                           out_vld_o,
  output logic signed [DW-1:0]           out_i_o,
  output logic signed [DW-1:0]           out_q_o
);
  // state   | meaning
  // WAIT_IN | accepting input samples until r_need of them have arrived
  // CALC    | one output issued per enabled cycle, phase advanced by step_i

  localparam int CW    = FIR_CO_WIDTH;
  localparam int IW    = CW + FRAC_W + 2;
  localparam int PW    = DW + CW;
  localparam int AW    = PW + 3;
  localparam int RND   = 2**(CW-2);
  localparam int SHIFT = CW - 1;

  typedef enum logic {S_WAIT_IN, S_CALC} state_t;

  state_t                r_state;
  logic [1:0]            r_need;
  logic [PH_W-1:0]       r_mu;
  logic signed [DW-1:0]  r_xi [P_LEN];
  logic signed [DW-1:0]  r_xq [P_LEN];
  logic                  r_v1, r_v2;
  logic signed [CW-1:0]  r_c  [P_LEN];
  logic signed [DW-1:0]  r_si [P_LEN];
  logic signed [DW-1:0]  r_sq [P_LEN];
  logic signed [PW-1:0]  r_pi [P_LEN];
  logic signed [PW-1:0]  r_pq [P_LEN];

  logic                  w_accept, w_issue;
  logic [PH_W+1:0]       w_mu_n;
  logic [1:0]            w_carry;
  logic signed [CW-1:0]  w_c [P_LEN];
  logic signed [AW-1:0]  w_sum_i, w_sum_q;

  function automatic logic signed [CW-1:0] interp(input logic signed [CW-1:0] c1,
                                                  input logic signed [CW-1:0] c2,
                                                  input logic [FRAC_W-1:0]    f);
    logic signed [IW-1:0] d, prod;
    d    = IW'(c2) - IW'(c1);
    prod = d * $signed({{(IW-FRAC_W){1'b0}}, f});
    return CW'(IW'(c1) + ((prod + IW'(2**(FRAC_W-1))) >>> FRAC_W));
  endfunction

  function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    sh = (acc + AW'(RND)) >>> SHIFT;
    if (sh > AW'(2**(DW-1)-1))         return DW'(2**(DW-1)-1);
    else if (sh < AW'(-(2**(DW-1))))   return DW'(-(2**(DW-1)));
    else                               return DW'(sh);
  endfunction

  // Ready is forced low while reset or clear is active so the clear cycle drops its sample.
  assign in_rdy_o   = (r_state == S_WAIT_IN) && en_i && !rst && !clr_i;
  assign w_accept   = in_vld_i && in_rdy_o;
  assign w_issue    = (r_state == S_CALC) && en_i;
  assign w_mu_n     = {2'b00, r_mu} + step_i;
  assign w_carry    = w_mu_n[PH_W+1:PH_W];
  assign rd_addr1_o = {1'b0, r_mu[PH_W-1:FRAC_W]};
  assign rd_addr2_o = rd_addr1_o + (L_LDN+1)'(1);

  always_comb begin
    for (int j = 0; j < P_LEN; j++)
      w_c[j] = interp(rd_data1_i[j*CW +: CW], rd_data2_i[j*CW +: CW], r_mu[FRAC_W-1:0]);
  end

  always_comb begin
    w_sum_i = '0;
    w_sum_q = '0;
    for (int j = 0; j < P_LEN; j++) begin
      w_sum_i = w_sum_i + AW'(r_pi[j]);
      w_sum_q = w_sum_q + AW'(r_pq[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_state   <= S_WAIT_IN;
      r_need    <= 2'd1;
      r_mu      <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_vld_o <= 1'b0;
      out_i_o   <= '0;
      out_q_o   <= '0;
      for (int j = 0; j < P_LEN; j++) begin
        r_xi[j] <= '0;
        r_xq[j] <= '0;
      end
    end else begin
      r_v1      <= w_issue;
      r_v2      <= r_v1;
      out_vld_o <= r_v2;
      if (r_v2) begin
        out_i_o <= round_sat(w_sum_i);
        out_q_o <= round_sat(w_sum_q);
      end
      case (r_state)
        S_WAIT_IN: begin
          if (w_accept) begin
            for (int j = P_LEN-1; j > 0; j--) begin
              r_xi[j] <= r_xi[j-1];
              r_xq[j] <= r_xq[j-1];
            end
            r_xi[0] <= in_i_i;
            r_xq[0] <= in_q_i;
            r_need  <= r_need - 2'd1;
            if (r_need == 2'd1) r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (en_i) begin
            r_mu <= w_mu_n[PH_W-1:0];
            if (w_carry != 2'd0) begin
              r_need  <= w_carry;
              r_state <= S_WAIT_IN;
            end
          end
        end
        default: r_state <= S_WAIT_IN;
      endcase
    end
  end

  // Datapath stages carry no reset; the valid pipe alone decides what reaches the output.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      for (int j = 0; j < P_LEN; j++) begin
        r_c[j]  <= w_c[j];
        r_si[j] <= r_xi[j];
        r_sq[j] <= r_xq[j];
      end
    end
    if (r_v1) begin
      for (int j = 0; j < P_LEN; j++) begin
        r_pi[j] <= $signed({{DW{r_c[j][CW-1]}}, r_c[j]}) * $signed({{CW{r_si[j][DW-1]}}, r_si[j]});
        r_pq[j] <= $signed({{DW{r_c[j][CW-1]}}, r_c[j]}) * $signed({{CW{r_sq[j][DW-1]}}, r_sq[j]});
      end
    end
  end

endmodule

// File: tb/tb_poly_resamp_fir.sv
// Bench for poly_resamp_fir: directed vectors, corner sequences and randomized
// streams checked against a position-based model of the resampler.
module tb_poly_resamp_fir;
  logic               clk = 1'b0;
  logic               rst, en, clr, in_vld, in_rdy, out_vld;
  logic [15:0]        step;
  logic signed [15:0] in_i, in_q, out_i, out_q;
  logic [6:0]         a1, a2;
  logic [83:0]        d1, d2;

  int n_cmp  = 0;
  int n_fail = 0;
  logic signed [13:0] lut [65][6];
  int samp_i[$];
  int samp_q[$];

  typedef struct {
    int c1; int c2; int f; int x; int e0; int e1;
  } vec_t;

  poly_resamp_fir dut (
    .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .step_i(step),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_i_i(in_i), .in_q_i(in_q),
    .rd_addr1_o(a1), .rd_addr2_o(a2), .rd_data1_i(d1), .rd_data2_i(d2),
    .out_vld_o(out_vld), .out_i_o(out_i), .out_q_o(out_q)
  );

  always #5 clk = ~clk;

  always_comb begin
    d1 = '0;
    d2 = '0;
    for (int j = 0; j < 6; j++) begin
      d1[j*14 +: 14] = lut[int'(a1)][j];
      d2[j*14 +: 14] = lut[int'(a2)][j];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_lut();
    for (int r = 0; r < 65; r++)
      for (int j = 0; j < 6; j++) lut[r][j] = '0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    en = 0; in_vld = 0; clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic wait_out(input int maxc, output int lat,
                          output logic signed [15:0] vi, output logic signed [15:0] vq);
    lat = -1; vi = 0; vq = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (out_vld) begin
        lat = i; vi = out_i; vq = out_q;
        break;
      end
    end
  endtask

  function automatic int rnd_sat(input longint a);
    longint r;
    r = (a + 4096) >>> 13;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  // Output k sits at absolute input position k*step (units of 2**14 per sample);
  // the samples already consumed are floor(position)+1, newest first in the taps.
  function automatic void model(input int k, input int stp, output int ei, output int eq,
                                output bit ok);
    longint pos, ai, aq;
    int n, mu, row, f, c1, c2, c, idx, xi, xq;
    pos = longint'(k) * stp;
    n   = int'(pos >> 14) + 1;
    mu  = int'(pos % 16384);
    row = mu >> 8;
    f   = mu & 255;
    ok  = (n <= samp_i.size());
    ai  = 0; aq = 0;
    for (int j = 0; j < 6; j++) begin
      c1  = lut[row][j];
      c2  = lut[row+1][j];
      c   = c1 + (((c2 - c1) * f + 128) >>> 8);
      idx = n - 1 - j;
      xi  = (ok && idx >= 0) ? samp_i[idx] : 0;
      xq  = (ok && idx >= 0) ? samp_q[idx] : 0;
      ai += longint'(c) * xi;
      aq += longint'(c) * xq;
    end
    ei = rnd_sat(ai);
    eq = rnd_sat(aq);
  endfunction

  task automatic rand_seg(input int stp, input int nout);
    int k, cyc, ei, eq;
    bit ok;
    k = 0; cyc = 0;
    do_clr();
    samp_i.delete();
    samp_q.delete();
    for (int r = 0; r < 65; r++)
      for (int j = 0; j < 6; j++) lut[r][j] = 14'(int'($urandom_range(0, 8000)) - 4000);
    step = 16'(stp);
    while (k < nout && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (out_vld) begin
        model(k, stp, ei, eq, ok);
        check("rand_hist_avail", longint'(ok), 1);
        check("rand_out_i", out_i, ei);
        check("rand_out_q", out_q, eq);
        k++;
      end
      en     = ($urandom_range(0, 9) != 0);
      in_vld = ($urandom_range(0, 9) < 7);
      in_i   = 16'($urandom);
      in_q   = 16'($urandom);
      #1;
      if (in_vld && in_rdy) begin
        samp_i.push_back(int'(in_i));
        samp_q.push_back(int'(in_q));
      end
    end
    check("rand_out_count", k, nout);
  endtask

  initial begin
    vec_t tv[7];
    int lat, cnt;
    int exp_a[4];
    logic signed [15:0] vi, vq;

    tv[0] = '{100, 201, 128, 8192, 100, 151};
    tv[1] = '{-100, 100, 64, 8192, -100, -50};
    tv[2] = '{0, -1, 128, 8192, 0, 0};
    tv[3] = '{0, -3, 128, 8192, 0, -1};
    tv[4] = '{4096, 4096, 255, 3, 2, 2};
    tv[5] = '{4096, 4096, 255, -3, -1, -1};
    tv[6] = '{1000, -1000, 200, -16384, -2000, 1124};
    exp_a = '{0, 16, 32, 48};

    rst = 1; en = 1; clr = 0; in_vld = 0; step = 16'd16384; in_i = 0; in_q = 0;
    clear_lut();

    // reset state
    @(negedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    rst = 0;
    #1;
    check("idle_in_rdy", in_rdy, 1);
    check("idle_addr1", a1, 0);
    check("idle_addr2", a2, 1);

    // directed interpolation/rounding vectors: output 0 at mu=0, output 1 at frac f
    for (int v = 0; v < 7; v++) begin
      do_clr();
      clear_lut();
      lut[0][0] = 14'(tv[v].c1);
      lut[1][0] = 14'(tv[v].c2);
      step = 16'(tv[v].f);
      en = 1; in_vld = 1; in_i = 16'(tv[v].x); in_q = 0;
      @(negedge clk);
      in_vld = 0;
      wait_out(8, lat, vi, vq);
      check("tv_latency", lat, 3);
      check("tv_out0", vi, tv[v].e0);
      @(negedge clk);
      check("tv_vld1", out_vld, 1);
      check("tv_out1", out_i, tv[v].e1);
    end

    // ratio 1 impulse response and latency
    do_clr();
    clear_lut();
    lut[0][0] = 14'sd8191;
    step = 16'd16384;
    en = 1; in_vld = 1; in_i = 1000; in_q = -500;
    @(negedge clk);
    in_i = 0; in_q = 0;
    check("r1_rdy_in_calc", in_rdy, 0);
    wait_out(8, lat, vi, vq);
    check("r1_latency", lat, 3);
    check("r1_out_i", vi, 1000);
    check("r1_out_q", vq, -500);
    for (int i = 0; i < 3; i++) begin
      wait_out(4, lat, vi, vq);
      check("r1_tail_seen", longint'(lat > 0), 1);
      check("r1_tail_i", vi, 0);
    end

    // upsample x4: four consecutive outputs per input, row stepping by 16
    do_clr();
    clear_lut();
    step = 16'd4096;
    en = 1; in_vld = 1; in_i = 100; in_q = 0;
    @(negedge clk);
    in_vld = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("up4_addr1", a1, exp_a[i]);
      check("up4_rdy_low", in_rdy, 0);
      if (out_vld) cnt++;
    end
    @(negedge clk);
    check("up4_rdy_back", in_rdy, 1);
    if (out_vld) cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_vld) cnt++;
    end
    check("up4_out_count", cnt, 4);

    // last phase row: addr2 reaches the extra row 64
    do_clr();
    step = 16'd16128;
    en = 1; in_vld = 1;
    @(negedge clk);
    in_vld = 0;
    @(negedge clk);
    check("wrap_addr1", a1, 63);
    check("wrap_addr2", a2, 64);

    // saturation with coefficients summing to 1.5
    do_clr();
    for (int r = 0; r < 65; r++)
      for (int j = 0; j < 6; j++) lut[r][j] = 14'sd2048;
    step = 16'd16384;
    en = 1; in_vld = 1; in_i = 32767; in_q = -32768;
    wait_out(8, lat, vi, vq);
    check("sat_first_i", vi, 8192);
    check("sat_first_q", vq, -8192);
    for (int i = 0; i < 7; i++) wait_out(6, lat, vi, vq);
    check("sat_out_i", vi, 32767);
    check("sat_out_q", vq, -32768);
    in_vld = 0;

    // clear with results in flight
    do_clr();
    clear_lut();
    for (int j = 0; j < 6; j++) lut[0][j] = 14'sd4096;
    step = 16'd0;
    en = 1; in_vld = 1; in_i = 2000; in_q = 2000;
    @(negedge clk);
    in_vld = 0;
    wait_out(8, lat, vi, vq);
    check("clr_pre_latency", lat, 3);
    check("clr_pre_out", vi, 1000);
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0; en = 0;
    check("clr_out_zero", out_i, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_vld) cnt++;
      @(negedge clk);
    end
    check("clr_no_stale_vld", cnt, 0);
    step = 16'd16384;
    en = 1; in_vld = 1; in_i = 600; in_q = -600;
    @(negedge clk);
    in_vld = 0;
    wait_out(8, lat, vi, vq);
    check("clr_post_latency", lat, 3);
    check("clr_post_i", vi, 300);
    check("clr_post_q", vq, -300);

    // randomized streams against the position model
    rand_seg(16384, 40);
    rand_seg(4096, 60);
    rand_seg(32768, 30);
    rand_seg(49151, 30);
    rand_seg(int'($urandom_range(1000, 49000)), 50);
    rand_seg(int'($urandom_range(1000, 49000)), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
